// File: rtl/cpu_run_ctrl_if.sv
// Board/CPU-side signal bundle for the run/step sequencer.
// The master side drives raw buttons, the mode switch and CPU state.
interface cpu_run_ctrl_if #(
    parameter int unsigned CNT_W = 16
);
    logic             btn_step;
    logic             btn_reset;
    logic             sw_mode;
    logic [3:0]       current_state;
    logic             cpu_en;
    logic             rst_out;
    logic             pause;
    logic             mode;
    logic             step_busy;
    logic [CNT_W-1:0] instr_count;

    modport master (
        output btn_step,
        output btn_reset,
        output sw_mode,
        output current_state,
        input  cpu_en,
        input  rst_out,
        input  pause,
        input  mode,
        input  step_busy,
        input  instr_count
    );

    modport slave (
        input  btn_step,
        input  btn_reset,
        input  sw_mode,
        input  current_state,
        output cpu_en,
        output rst_out,
        output pause,
        output mode,
        output step_busy,
        output instr_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer: debounced board controls gate the CPU clock enable
// so the CPU free-runs or advances one instruction per step press.
module cpu_run_ctrl #(
    parameter int unsigned DB_CYCLES   = 1000000,
    parameter int unsigned RST_HOLD    = 16,
    parameter logic [3:0]  FETCH_STATE = 4'd0,
    parameter int unsigned CNT_W       = 16
) (
    input logic           clk,
    input logic           rst,
    cpu_run_ctrl_if.slave bus
);
    localparam int DB_W   = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam int HOLD_W = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DB_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        S_RST,
        S_IDLE,
        S_RUN,
        S_STEP
    } state_t;

    // bit 0 = step button, bit 1 = reset button, bit 2 = mode switch
    logic [2:0]      w_raw;
    logic [2:0]      r_sync1;
    logic [2:0]      r_sync2;
    logic [2:0]      r_db;
    logic [2:0]      r_db_d;
    logic [DB_W-1:0] r_dbc [3];

    logic w_step_p;
    logic w_reset_p;
    logic w_mode;
    logic w_fetch;

    state_t            r_state;
    state_t            w_next;
    logic [HOLD_W-1:0] r_hold;
    logic [HOLD_W-1:0] w_hold_nxt;
    logic              r_left;
    logic              w_left_nxt;
    logic              w_en;
    logic              r_rst_out;
    logic              r_pause;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;

    assign w_raw = {bus.sw_mode, bus.btn_reset, bus.btn_step};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
            r_db_d  <= '0;
        end else begin
            r_sync1 <= w_raw;
            r_sync2 <= r_sync1;
            r_db_d  <= r_db;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_db <= '0;
            for (int i = 0; i < 3; i++) begin
                r_dbc[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (r_sync2[i] == r_db[i]) begin
                    r_dbc[i] <= '0;
                end else if (r_dbc[i] == DB_LAST) begin
                    r_db[i]  <= r_sync2[i];
                    r_dbc[i] <= '0;
                end else begin
                    r_dbc[i] <= r_dbc[i] + 1'b1;
                end
            end
        end
    end

    assign w_step_p  = r_db[0] & ~r_db_d[0];
    assign w_reset_p = r_db[1] & ~r_db_d[1];
    assign w_mode    = r_db[2];
    assign w_fetch   = (bus.current_state == FETCH_STATE);

    always_comb begin
        w_next     = r_state;
        w_hold_nxt = r_hold;
        w_left_nxt = r_left;
        w_en       = 1'b0;
        unique case (r_state)
            S_RST: begin
                if (r_hold == '0) begin
                    w_next = w_mode ? S_RUN : S_IDLE;
                end else begin
                    w_hold_nxt = r_hold - 1'b1;
                end
            end
            S_IDLE: begin
                if (w_mode) begin
                    w_next = S_RUN;
                end else if (w_step_p) begin
                    w_next     = S_STEP;
                    w_left_nxt = 1'b0;
                end
            end
            S_RUN: begin
                // only stop on an instruction boundary
                if (!w_mode && w_fetch) begin
                    w_next = S_IDLE;
                end else begin
                    w_en = 1'b1;
                end
            end
            S_STEP: begin
                w_en = !r_left || !w_fetch;
                if (w_en) begin
                    w_left_nxt = 1'b1;
                end
                if (r_left && w_fetch) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_RST;
            end
        endcase
        if (w_reset_p) begin
            w_next     = S_RST;
            w_hold_nxt = HOLD_INIT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_RST;
            r_hold    <= HOLD_INIT;
            r_left    <= 1'b0;
            r_rst_out <= 1'b1;
            r_pause   <= 1'b1;
            r_busy    <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_hold    <= w_hold_nxt;
            r_left    <= w_left_nxt;
            r_rst_out <= (w_next == S_RST);
            r_pause   <= (w_next != S_RUN);
            r_busy    <= (w_next == S_STEP);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_reset_p) begin
            r_cnt <= '0;
        end else if (w_en && w_fetch) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign bus.cpu_en      = w_en;
    assign bus.rst_out     = r_rst_out;
    assign bus.pause       = r_pause;
    assign bus.mode        = w_mode;
    assign bus.step_busy   = r_busy;
    assign bus.instr_count = r_cnt;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Bench for cpu_run_ctrl: directed scenarios plus random button/switch
// activity, checked every cycle against a behavioural model.
module tb_cpu_run_ctrl;
    localparam int DB   = 4;
    localparam int HOLD = 3;
    localparam int CW   = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(CW)) bus ();

    cpu_run_ctrl #(
        .DB_CYCLES  (DB),
        .RST_HOLD   (HOLD),
        .FETCH_STATE(4'd0),
        .CNT_W      (CW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // model of the conditioned inputs: sync pipe and sample history
    bit m_valid = 1'b0;
    bit pipe1 [3];
    bit pipe2 [3];
    bit db    [3];
    bit dbp   [3];
    bit hist  [3][$];

    // model of the sequencer: m_hold >= 0 means CPU reset is held
    int m_hold;
    bit m_run;
    bit m_step;
    bit m_left;
    int m_count;
    bit m_rst_out;
    bit m_pause;
    bit m_busy;

    bit stuck = 1'b0;
    int en_cnt, rst_cnt, busy_cnt, fetches;

    function automatic void model_reset();
        for (int i = 0; i < 3; i++) begin
            pipe1[i] = 1'b0;
            pipe2[i] = 1'b0;
            db[i]    = 1'b0;
            dbp[i]   = 1'b0;
            hist[i].delete();
            for (int k = 0; k < DB; k++) hist[i].push_back(1'b0);
        end
        m_hold    = HOLD - 1;
        m_run     = 1'b0;
        m_step    = 1'b0;
        m_left    = 1'b0;
        m_count   = 0;
        m_rst_out = 1'b1;
        m_pause   = 1'b1;
        m_busy    = 1'b0;
        m_valid   = 1'b1;
    endfunction

    function automatic bit exp_en(bit [3:0] cs);
        if (m_hold >= 0) return 1'b0;
        if (m_run) return !(!db[2] && cs == 4'd0);
        if (m_step) return !m_left || cs != 4'd0;
        return 1'b0;
    endfunction

    function automatic void model_step(bit [2:0] raw, bit [3:0] cs);
        bit en, sp, rp, md, was, all;
        en  = exp_en(cs);
        sp  = db[0] && !dbp[0];
        rp  = db[1] && !dbp[1];
        md  = db[2];
        was = m_left;
        if (rp) begin
            m_hold = HOLD - 1;
            m_run  = 1'b0;
            m_step = 1'b0;
        end else if (m_hold >= 0) begin
            if (m_hold == 0) begin
                m_hold = -1;
                m_run  = md;
            end else begin
                m_hold--;
            end
        end else if (m_run) begin
            if (!md && cs == 4'd0) m_run = 1'b0;
        end else if (m_step) begin
            if (en) m_left = 1'b1;
            if (was && cs == 4'd0) m_step = 1'b0;
        end else if (md) begin
            m_run = 1'b1;
        end else if (sp) begin
            m_step = 1'b1;
            m_left = 1'b0;
        end
        if (rp) m_count = 0;
        else if (en && cs == 4'd0) m_count = (m_count + 1) % (1 << CW);
        m_rst_out = (m_hold >= 0);
        m_pause   = !m_run;
        m_busy    = m_step;
        // a debounced value flips once the last DB sync samples all disagree
        for (int i = 0; i < 3; i++) begin
            dbp[i] = db[i];
            hist[i].push_back(pipe2[i]);
            void'(hist[i].pop_front());
            all = 1'b1;
            foreach (hist[i][k]) if (hist[i][k] == db[i]) all = 1'b0;
            if (all) db[i] = !db[i];
            pipe2[i] = pipe1[i];
            pipe1[i] = raw[i];
        end
    endfunction

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic       s_en, s_ro;
        logic [3:0] cs;
        bit   [2:0] raw;
        bit         r;
        @(negedge clk);
        cs   = bus.current_state;
        s_en = bus.cpu_en;
        s_ro = bus.rst_out;
        if (m_valid) begin
            chk("cpu_en", 16'(s_en), 16'(exp_en(cs)));
            chk("rst_out", 16'(s_ro), 16'(m_rst_out));
            chk("pause", 16'(bus.pause), 16'(m_pause));
            chk("mode", 16'(bus.mode), 16'(db[2]));
            chk("step_busy", 16'(bus.step_busy), 16'(m_busy));
            chk("instr_count", 16'(bus.instr_count), 16'(m_count));
        end
        if (s_en === 1'b1) en_cnt++;
        if (s_ro === 1'b1) rst_cnt++;
        if (bus.step_busy === 1'b1) busy_cnt++;
        if (s_en === 1'b1 && cs == 4'd0) fetches++;
        raw = {bus.sw_mode, bus.btn_reset, bus.btn_step};
        r   = rst;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else if (m_valid) model_step(raw, cs);
        // CPU stand-in: 4-state instruction loop 0->1->2->3->0
        if (s_ro === 1'b1) bus.current_state = 4'd0;
        else if (s_en === 1'b1 && !stuck) bus.current_state = (cs + 4'd1) % 4'd4;
    endtask

    task automatic ticks(int n);
        repeat (n) tick();
    endtask

    initial begin
        bit found;
        bus.btn_step      = 1'b0;
        bus.btn_reset     = 1'b0;
        bus.sw_mode       = 1'b0;
        bus.current_state = 4'd0;
        rst = 1'b1;
        tick();
        rst = 1'b0;

        rst_cnt = 0;
        ticks(10);
        chk("rst_hold_len", 16'(rst_cnt), 16'd3);
        chk("idle_pause", 16'(bus.pause), 16'd1);
        chk("idle_en", 16'(bus.cpu_en), 16'd0);
        chk("idle_count", 16'(bus.instr_count), 16'd0);

        en_cnt = 0;
        busy_cnt = 0;
        bus.btn_step = 1'b1;
        ticks(8);
        bus.btn_step = 1'b0;
        ticks(16);
        chk("step_en_cycles", 16'(en_cnt), 16'd4);
        chk("step_busy_cycles", 16'(busy_cnt), 16'd5);
        chk("step_count", 16'(bus.instr_count), 16'd1);
        chk("step_cs", 16'(bus.current_state), 16'd0);

        en_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            bus.btn_step = ~bus.btn_step;
            ticks(2);
        end
        bus.btn_step = 1'b1;
        ticks(10);
        bus.btn_step = 1'b0;
        ticks(14);
        chk("bounce_one_step", 16'(en_cnt), 16'd4);

        en_cnt = 0;
        bus.btn_step = 1'b1;
        ticks(3);
        bus.btn_step = 1'b0;
        ticks(12);
        chk("short_pulse", 16'(en_cnt), 16'd0);

        bus.sw_mode = 1'b1;
        ticks(12);
        chk("run_pause", 16'(bus.pause), 16'd0);
        chk("run_en", 16'(bus.cpu_en), 16'd1);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (bus.current_state == 4'd2);
        end
        chk("wait_cs2", 16'(found), 16'd1);
        bus.sw_mode = 1'b0;
        ticks(20);
        chk("stop_pause", 16'(bus.pause), 16'd1);
        chk("stop_cs", 16'(bus.current_state), 16'd0);
        chk("stop_en", 16'(bus.cpu_en), 16'd0);

        bus.btn_step = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 30 && !found; i++) begin
            tick();
            found = (bus.step_busy === 1'b1 && bus.current_state == 4'd2);
        end
        chk("wait_step_cs2", 16'(found), 16'd1);
        stuck = 1'b1;
        en_cnt = 0;
        ticks(10);
        chk("stuck_en", 16'(en_cnt), 16'd10);
        bus.btn_step  = 1'b0;
        bus.btn_reset = 1'b1;
        rst_cnt = 0;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = (bus.rst_out === 1'b1);
        end
        chk("wait_rst_out", 16'(found), 16'd1);
        chk("rstp_busy", 16'(bus.step_busy), 16'd0);
        chk("rstp_en", 16'(bus.cpu_en), 16'd0);
        chk("rstp_count", 16'(bus.instr_count), 16'd0);
        stuck = 1'b0;
        ticks(8);
        chk("rstp_hold_len", 16'(rst_cnt), 16'd3);
        bus.btn_reset = 1'b0;
        ticks(10);

        bus.sw_mode = 1'b1;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        fetches = 0;
        for (int i = 0; i < 200 && fetches < 17; i++) tick();
        chk("wrap_fetches", 16'(fetches), 16'd17);
        chk("wrap_count", 16'(bus.instr_count), 16'd1);
        busy_cnt = 0;
        bus.btn_step = 1'b1;
        ticks(10);
        bus.btn_step = 1'b0;
        ticks(10);
        chk("run_step_ignored", 16'(busy_cnt), 16'd0);
        chk("still_running", 16'(bus.pause), 16'd0);

        for (int s = 0; s < 60; s++) begin
            case ($urandom_range(0, 6))
                0: bus.btn_step = ~bus.btn_step;
                1: bus.btn_reset = ~bus.btn_reset;
                2: bus.sw_mode = ~bus.sw_mode;
                3: stuck = ~stuck;
                4: begin
                    for (int k = 0; k < 6; k++) begin
                        bus.btn_step = ~bus.btn_step;
                        ticks($urandom_range(1, 3));
                    end
                end
                5: begin
                    if ($urandom_range(0, 3) == 0) begin
                        rst = 1'b1;
                        tick();
                        rst = 1'b0;
                    end
                end
                default: ;
            endcase
            ticks($urandom_range(1, 25));
        end
        stuck = 1'b0;
        bus.btn_step  = 1'b0;
        bus.btn_reset = 1'b0;
        bus.sw_mode   = 1'b0;
        ticks(40);
        chk("final_pause", 16'(bus.pause), 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end
endmodule
